// File: rtl/top_mul_share_sched.sv
// Round-robin scheduler that time-shares one unsigned x signed multiplier among
// NUM_REQ requesters. It keeps one op in flight and registers the result, which
// is handed off with valid/ready and tagged with the owning requester's index.
module top_mul_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 2,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic                             busy,
  output logic [31:0]                      ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [ID_WIDTH-1:0]            last;
  logic [ID_WIDTH-1:0]            tag;
  logic [DIN0_WIDTH-1:0]          op0;
  logic [DIN1_WIDTH-1:0]          op1;
  logic [ID_WIDTH-1:0]            win;
  logic [ID_WIDTH-1:0]            idx;
  logic                           found;
  logic                           window;
  logic                           accept;
  int unsigned                    cand;
  logic signed [DIN0_WIDTH+DIN1_WIDTH:0] full;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last) + k) % NUM_REQ;
      idx  = cand[ID_WIDTH-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Accept window: idle, or the pending response is being consumed this cycle.
  always_comb begin
    window    = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept    = found && window && !ap_rst;
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Shared multiplier; zero-extend din0 so it multiplies as a non-negative value.
  always_comb begin
    full = $signed({1'b0, op0}) * $signed(op1);
  end

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, result register, handshake and completion counter.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last      <= ID_WIDTH'(NUM_REQ - 1);
      tag       <= '0;
      op0       <= '0;
      op1       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_dout  <= '0;
      ops_done  <= '0;
    end else begin
      if (accept) begin
        last <= win;
        tag  <= win;
        op0  <= req_din0[win*DIN0_WIDTH +: DIN0_WIDTH];
        op1  <= req_din1[win*DIN1_WIDTH +: DIN1_WIDTH];
      end
      if (state == EXEC) begin
        rsp_dout  <= full[DOUT_WIDTH-1:0];
        rsp_id    <= tag;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        ops_done  <= ops_done + 32'd1;
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_top_mul_share_sched.sv
// Directed bench for top_mul_share_sched: a vector table of single ops plus
// hand-written sequences for reset, round-robin, back-pressure and skip cases.
module tb_top_mul_share_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   req_din0;
  logic [127:0] req_din1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_dout;
  logic         busy;
  logic [31:0]  ops_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ops = 0;

  typedef struct {
    int          id;
    logic [1:0]  d0;
    logic [31:0] d1;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [6];

  top_mul_share_sched #(
    .NUM_REQ(4), .ID_WIDTH(2), .DIN0_WIDTH(2), .DIN1_WIDTH(32), .DOUT_WIDTH(32)
  ) dut (
    .ap_clk(clk), .ap_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] d0, input logic [31:0] d1);
    req_din0[i*2 +: 2]   = d0;
    req_din1[i*32 +: 32] = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ops = 0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Single op through an idle scheduler with the consumer always ready.
  task automatic run_op(input int id, input logic [1:0] d0, input logic [31:0] d1,
                        input logic [31:0] dout);
    logic [3:0] oh;
    oh = 4'(1 << id);
    set_req(id, d0, d1);
    rsp_ready = 1'b1;
    req_valid = oh;
    #1;
    check("op_ready", 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    #1;
    check("op_exec_busy", 32'(busy), 32'd1);
    check("op_exec_novalid", 32'(rsp_valid), 32'd0);
    step();
    check("op_rsp_valid", 32'(rsp_valid), 32'd1);
    check("op_rsp_id", 32'(rsp_id), 32'(id));
    check("op_rsp_dout", rsp_dout, dout);
    step();
    exp_ops++;
    check("op_ops_done", ops_done, exp_ops);
    check("op_done_novalid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rr_exp [4];
    vecs[0] = '{2, 2'd2, 32'hFFFF_FFFB, 32'hFFFF_FFF6};
    vecs[1] = '{0, 2'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFD};
    vecs[2] = '{1, 2'd0, 32'h8000_0000, 32'h0000_0000};
    vecs[3] = '{3, 2'd1, 32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{1, 2'd2, 32'h4000_0000, 32'h8000_0000};
    rr_exp  = '{32'd0, 32'd101, 32'd204, 32'd309};

    // Reset state, with every requester asserting valid.
    rst = 1'b1;
    req_valid = 4'hF;
    req_din0 = '0;
    req_din1 = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_dout", rsp_dout, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", ops_done, 32'd0);
    req_valid = '0;
    do_reset();

    // Table-driven single ops.
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].id, vecs[i].d0, vecs[i].d1, vecs[i].dout);

    // Reset asserted mid-EXEC drops the op immediately.
    set_req(0, 2'd1, 32'd5);
    req_valid = 4'b0001;
    step();
    check("rx_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_ops = 0;
    #1;
    check("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rx_ready", 32'(req_ready), 32'd0);
    check("rx_ops_done", ops_done, 32'd0);
    check("rx_busy", 32'(busy), 32'd0);
    req_valid = '0;
    step();
    rst = 1'b0;
    step();
    step();
    check("rx_no_stale", 32'(rsp_valid), 32'd0);
    run_op(1, 2'd3, 32'd7, 32'd21);

    // Round-robin with all four requesters valid and consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 32'(100 + i));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      if (k > 0) begin
        exp_ops++;
        check("rr_ops_done", ops_done, exp_ops);
      end
      check("rr_exec_noready", 32'(req_ready), 32'd0);
      step();
      check("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      check("rr_rsp_dout", rsp_dout, rr_exp[k % 4]);
    end
    req_valid = '0;
    step();
    exp_ops++;
    check("rr_final_ops", ops_done, exp_ops);
    check("rr_idle", 32'(busy), 32'd0);

    // Back-pressure: hold the response for 10 cycles, then same-cycle accept.
    set_req(2, 2'd2, 32'h1234_5678);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1000;
    set_req(3, 2'd3, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_dout", rsp_dout, 32'h2468_ACF0);
      check("bp_id", 32'(rsp_id), 32'd2);
      check("bp_noready", 32'(req_ready), 32'd0);
      step();
    end
    check("bp_ops_held", ops_done, exp_ops);
    rsp_ready = 1'b1;
    #1;
    check("bp_accept", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    exp_ops++;
    check("bp_ops_done", ops_done, exp_ops);
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    step();
    check("bp_rsp3_id", 32'(rsp_id), 32'd3);
    check("bp_rsp3_dout", rsp_dout, 32'hFFFF_FFFD);
    step();
    exp_ops++;
    check("bp_ops_done2", ops_done, exp_ops);

    // Skip idle requesters: last=1, req1 and req3 valid -> 3 then 1.
    run_op(1, 2'd1, 32'd9, 32'd9);
    set_req(3, 2'd2, 32'h0000_0007);
    set_req(1, 2'd3, 32'hFFFF_FF00);
    req_valid = 4'b1010;
    #1;
    check("sk_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0010;
    step();
    check("sk_rsp3_id", 32'(rsp_id), 32'd3);
    check("sk_rsp3_dout", rsp_dout, 32'h0000_000E);
    check("sk_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    exp_ops++;
    check("sk_ops_done", ops_done, exp_ops);
    step();
    check("sk_rsp1_id", 32'(rsp_id), 32'd1);
    check("sk_rsp1_dout", rsp_dout, 32'hFFFF_FD00);
    step();
    exp_ops++;
    check("sk_ops_done2", ops_done, exp_ops);
    step();
    step();
    check("sk_idle_ready_ignored", ops_done, exp_ops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
